// File: rtl/riscv_ex_arbiter.sv
// Round-robin arbiter sharing one riscv_ex ALU between two requesters.
// A tag pipeline matching the EX latency routes each result back to its owner.
module riscv_ex_arbiter #(
    parameter int XLEN   = 32,
    parameter int REGA   = 5,
    parameter int EX_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    input  logic            req1_valid,
    output logic            req0_ready,
    output logic            req1_ready,
    input  logic [REGA-1:0] req0_rd,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [5:0]      req0_shamt,
    input  logic [2:0]      req0_funct3,
    input  logic            req0_invertb,
    input  logic [REGA-1:0] req1_rd,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [5:0]      req1_shamt,
    input  logic [2:0]      req1_funct3,
    input  logic            req1_invertb,
    input  logic [1:0]      flush,
    output logic [REGA-1:0] ex_rdi,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [5:0]      ex_shamt,
    output logic [2:0]      ex_funct3,
    output logic            ex_invertb,
    input  logic [XLEN-1:0] ex_result,
    input  logic [REGA-1:0] ex_rd,
    output logic [1:0]      rsp_valid,
    output logic [XLEN-1:0] rsp_result,
    output logic [REGA-1:0] rsp_rd,
    output logic            busy
);

    logic [1:0]        eligible;
    logic              issue;
    logic              win;
    logic              last_grant;
    logic [EX_LAT-1:0] tag_vld;
    logic              tag_id [EX_LAT];

    // A flushed requester is never eligible, so a fresh tag can never be born flushed.
    always_comb begin
        eligible = {req1_valid & ~flush[1], req0_valid & ~flush[0]};
        issue    = |eligible;
        win      = eligible[1] & (~eligible[0] | ~last_grant);
    end

    assign req0_ready = eligible[0] & ~win;
    assign req1_ready = eligible[1] & win;

    always_comb begin
        ex_rdi     = '0;
        ex_a       = '0;
        ex_b       = '0;
        ex_shamt   = '0;
        ex_funct3  = '0;
        ex_invertb = 1'b0;
        if (issue) begin
            if (win) begin
                ex_rdi     = req1_rd;
                ex_a       = req1_a;
                ex_b       = req1_b;
                ex_shamt   = req1_shamt;
                ex_funct3  = req1_funct3;
                ex_invertb = req1_invertb;
            end else begin
                ex_rdi     = req0_rd;
                ex_a       = req0_a;
                ex_b       = req0_b;
                ex_shamt   = req0_shamt;
                ex_funct3  = req0_funct3;
                ex_invertb = req0_invertb;
            end
        end
    end

    // Tag pipeline valids: stage 0 captures the issue, later stages drop flushed owners.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            tag_vld    <= '0;
        end else begin
            if (issue) begin
                last_grant <= win;
            end
            tag_vld[0] <= issue;
            for (int k = 1; k < EX_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1] & ~flush[tag_id[k-1]];
            end
        end
    end

    // Tag pipeline owners: qualified by tag_vld, so no reset is needed.
    always_ff @(posedge clk) begin
        tag_id[0] <= win;
        for (int k = 1; k < EX_LAT; k++) begin
            tag_id[k] <= tag_id[k-1];
        end
    end

    // Response stage: last tag selects the owner, same-cycle flush masks it.
    assign rsp_valid[0] = tag_vld[EX_LAT-1] & ~tag_id[EX_LAT-1] & ~flush[0];
    assign rsp_valid[1] = tag_vld[EX_LAT-1] &  tag_id[EX_LAT-1] & ~flush[1];
    assign rsp_result   = ex_result;
    assign rsp_rd       = ex_rd;
    assign busy         = |tag_vld;

endmodule
